// File: rtl/sub_32bit_pipe.sv
// sub_32bit_pipe: two-stage pipelined subtractor, D = A - B, with borrow-out,
// signed-overflow and zero flags. The low half is subtracted in stage 1; the high
// half, using the registered carry from the low half, is subtracted in stage 2.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands A/B presented
//   in_ready   block accepts operands this cycle (combinational from out_ready)
//   A, B       minuend, subtrahend
//   out_valid  result registers hold a valid result
//   out_ready  consumer accepts the result this cycle
//   D          difference, A - B mod 2^WIDTH
//   BOUT       unsigned borrow out (A < B)
//   OVF        signed overflow of A - B
//   ZERO       D == 0
module sub_32bit_pipe #(
  parameter int unsigned WIDTH = 32  // even, >= 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int unsigned HALF = WIDTH / 2;

  // Stage 1: low-half result, carry into the high half, high-half operands.
  logic            r_v1;
  logic [HALF-1:0] r_lo;
  logic            r_cmid;
  logic [HALF-1:0] r_ahi;
  logic [HALF-1:0] r_bhi;

  // Stage 2: final result and flags.
  logic             r_v2;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_acc;
  logic             w_adv2;
  logic [HALF:0]    w_lo;
  logic [HALF:0]    w_hi;
  logic [WIDTH-1:0] w_d;

  // Stage 2 can take a new item when empty or when its item leaves this cycle;
  // stage 1 can then take a new item whenever it is empty or drains into stage 2.
  always_comb begin
    w_adv2   = r_v1 && (!r_v2 || out_ready);
    in_ready = !r_v1 || w_adv2;
    w_acc    = in_valid && in_ready;
  end

  // Subtraction as A + ~B + 1; the +1 enters at the low half, the carry crosses stages.
  assign w_lo = {1'b0, A[HALF-1:0]} + {1'b0, ~B[HALF-1:0]} + {{HALF{1'b0}}, 1'b1};
  assign w_hi = {1'b0, r_ahi} + {1'b0, ~r_bhi} + {{HALF{1'b0}}, r_cmid};
  assign w_d  = {w_hi[HALF-1:0], r_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_lo   <= '0;
      r_cmid <= 1'b0;
      r_ahi  <= '0;
      r_bhi  <= '0;
    end else begin
      if (w_acc) begin
        r_v1 <= 1'b1;
      end else if (w_adv2) begin
        r_v1 <= 1'b0;
      end
      if (w_acc) begin
        r_lo   <= w_lo[HALF-1:0];
        r_cmid <= w_lo[HALF];
        r_ahi  <= A[WIDTH-1:HALF];
        r_bhi  <= B[WIDTH-1:HALF];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_d    <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_v2 <= 1'b1;
      end else if (out_ready && r_v2) begin
        r_v2 <= 1'b0;
      end
      if (w_adv2) begin
        r_d    <= w_d;
        // No carry out of A + ~B + 1 means a borrow was needed.
        r_bout <= ~w_hi[HALF];
        // Overflow only when operand signs differ and the result sign differs from A.
        r_ovf  <= (r_ahi[HALF-1] != r_bhi[HALF-1]) && (w_hi[HALF-1] != r_ahi[HALF-1]);
        r_zero <= (w_d == '0);
      end
    end
  end

  assign out_valid = r_v2;
  assign D         = r_d;
  assign BOUT      = r_bout;
  assign OVF       = r_ovf;
  assign ZERO      = r_zero;

endmodule

// File: tb/tb_sub_32bit_pipe.sv
// Testbench for sub_32bit_pipe: directed corner cases, reset, backpressure and
// random streaming checked against an arithmetic reference model.
module tb_sub_32bit_pipe;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         BOUT;
  logic         OVF;
  logic         ZERO;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] stim_a[$];
  logic [W-1:0] stim_b[$];
  res_t         got[$];
  int           acc_cyc[$];
  int           out_cyc[$];

  sub_32bit_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D),
    .BOUT     (BOUT),
    .OVF      (OVF),
    .ZERO     (ZERO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t   r;
    longint sd;
    r.d    = a - b;
    r.bout = (a < b);
    sd     = longint'($signed(a)) - longint'($signed(b));
    r.ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    r.zero = (r.d == '0);
    return r;
  endfunction

  function automatic res_t sample();
    res_t r;
    r.d    = D;
    r.bout = BOUT;
    r.ovf  = OVF;
    r.zero = ZERO;
    return r;
  endfunction

  // Streams stim_a/stim_b through the DUT; mode 0 holds out_ready=1, mode 1 randomizes it.
  task automatic drive(input int mode, input int max_cycles, output bit timed_out);
    int sent;
    int n;
    sent = 0;
    n    = stim_a.size();
    got.delete();
    acc_cyc.delete();
    out_cyc.delete();
    for (int c = 0; c < max_cycles && got.size() < n; c++) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (sent < n) begin
        in_valid = 1'b1;
        A        = stim_a[sent];
        B        = stim_b[sent];
      end else begin
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
      end
      #1;
      if (out_valid && out_ready) begin
        got.push_back(sample());
        out_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        sent++;
      end
    end
    timed_out = (got.size() < n);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || D !== '0 || BOUT !== 1'b0 || OVF !== 1'b0 || ZERO !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: out_valid=%b D=%h BOUT=%b OVF=%b ZERO=%b required all 0",
               out_valid, D, BOUT, OVF, ZERO);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    rst = 1'b0;
    // Load two items with the output stalled so both stages are occupied.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (i < 2);
      A         = 32'd10 + i;
      B         = 32'd3;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || D !== 32'd7) begin
      bad++;
      $display("FAIL reset_preload: out_valid=%b D=%h required 1 / 00000007", out_valid, D);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || D !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_async: out_valid=%b D=%h in_ready=%b required 0 / 0 / 1",
               out_valid, D, in_ready);
    end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_no_stale: cycle %0d out_valid=%b in_ready=%b required 0 / 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_basic();
    bit to;
    stim_a = '{32'h0000_0005};
    stim_b = '{32'h0000_0003};
    drive(0, 20, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL basic_timeout: got %0d results required 1", got.size());
    end else begin
      total++;
      if (got[0].d !== 32'h2 || got[0].bout !== 1'b0 || got[0].ovf !== 1'b0
          || got[0].zero !== 1'b0) begin
        bad++;
        $display("FAIL basic_value: got D=%h B=%b O=%b Z=%b required 00000002 0 0 0",
                 got[0].d, got[0].bout, got[0].ovf, got[0].zero);
      end
      total++;
      if (out_cyc[0] - acc_cyc[0] != 2) begin
        bad++;
        $display("FAIL basic_latency: got %0d required 2", out_cyc[0] - acc_cyc[0]);
      end
    end
  endtask

  task automatic test_borrow_overflow();
    bit   to;
    res_t exp_r[5];
    stim_a = '{32'h0001_0000, 32'h0000_0000, 32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF};
    stim_b = '{32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF};
    exp_r[0] = '{d: 32'h0000_FFFF, bout: 1'b0, ovf: 1'b0, zero: 1'b0};
    exp_r[1] = '{d: 32'hFFFF_FFFF, bout: 1'b1, ovf: 1'b0, zero: 1'b0};
    exp_r[2] = '{d: 32'h0000_0000, bout: 1'b0, ovf: 1'b0, zero: 1'b1};
    exp_r[3] = '{d: 32'h7FFF_FFFF, bout: 1'b0, ovf: 1'b1, zero: 1'b0};
    exp_r[4] = '{d: 32'h8000_0000, bout: 1'b1, ovf: 1'b1, zero: 1'b0};
    drive(0, 30, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL corner_timeout: got %0d results required 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (got[i] !== exp_r[i]) begin
          bad++;
          $display("FAIL corner_%0d: got D=%h B=%b O=%b Z=%b required D=%h B=%b O=%b Z=%b", i,
                   got[i].d, got[i].bout, got[i].ovf, got[i].zero,
                   exp_r[i].d, exp_r[i].bout, exp_r[i].ovf, exp_r[i].zero);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ba[4];
    logic [W-1:0] bb[4];
    res_t         held;
    bit           have_held;
    int           sent;
    int           ngot;
    res_t         r;
    res_t         e;
    for (int i = 0; i < 4; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    sent      = 0;
    have_held = 0;
    held      = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (sent < 4);
      A         = (sent < 4) ? ba[sent] : $urandom;
      B         = (sent < 4) ? bb[sent] : $urandom;
      #1;
      if (out_valid) begin
        if (!have_held) begin
          held      = sample();
          have_held = 1;
        end else begin
          total++;
          if (sample() !== held) begin
            bad++;
            $display("FAIL bp_stable: cycle %0d got D=%h required D=%h", c, D, held.d);
          end
        end
      end
      if (in_valid && in_ready) sent++;
    end
    total++;
    if (sent != 2 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_fill: accepted %0d in_ready=%b required 2 / 0", sent, in_ready);
    end
    ngot = 0;
    for (int c = 0; c < 30 && ngot < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (sent < 4);
      A         = (sent < 4) ? ba[sent] : $urandom;
      B         = (sent < 4) ? bb[sent] : $urandom;
      #1;
      if (c == 0) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL bp_full_accept: in_ready=%b required 1", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        r = sample();
        e = model(ba[ngot], bb[ngot]);
        total++;
        if (r !== e) begin
          bad++;
          $display("FAIL bp_order_%0d: got D=%h B=%b O=%b Z=%b required D=%h B=%b O=%b Z=%b",
                   ngot, r.d, r.bout, r.ovf, r.zero, e.d, e.bout, e.ovf, e.zero);
        end
        ngot++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (ngot != 4 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_count: got %0d results out_valid=%b required 4 / 0", ngot, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit   to;
    res_t e;
    stim_a.delete();
    stim_b.delete();
    for (int i = 0; i < 100; i++) begin
      stim_a.push_back($urandom);
      stim_b.push_back((i % 10 == 0) ? stim_a[i] : $urandom);
    end
    drive(0, 200, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL b2b_timeout: got %0d results required 100", got.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        e = model(stim_a[i], stim_b[i]);
        total++;
        if (got[i] !== e || out_cyc[i] != acc_cyc[i] + 2 || acc_cyc[i] != acc_cyc[0] + i) begin
          bad++;
          $display("FAIL b2b_%0d: got D=%h B=%b O=%b Z=%b at +%0d required D=%h B=%b O=%b Z=%b at +2",
                   i, got[i].d, got[i].bout, got[i].ovf, got[i].zero,
                   out_cyc[i] - acc_cyc[i], e.d, e.bout, e.ovf, e.zero);
        end
      end
    end
  endtask

  task automatic test_random_stall();
    bit   to;
    res_t e;
    stim_a.delete();
    stim_b.delete();
    for (int i = 0; i < 60; i++) begin
      stim_a.push_back($urandom);
      stim_b.push_back($urandom);
    end
    drive(1, 600, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL stall_timeout: got %0d results required 60", got.size());
    end else begin
      for (int i = 0; i < 60; i++) begin
        e = model(stim_a[i], stim_b[i]);
        total++;
        if (got[i] !== e) begin
          bad++;
          $display("FAIL stall_%0d: got D=%h B=%b O=%b Z=%b required D=%h B=%b O=%b Z=%b",
                   i, got[i].d, got[i].bout, got[i].ovf, got[i].zero,
                   e.d, e.bout, e.ovf, e.zero);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    test_reset();
    test_basic();
    test_borrow_overflow();
    test_backpressure();
    test_back_to_back();
    test_random_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_32bit_pipe.md
Name: sub_32bit_pipe

Overview:
- Two-stage pipelined 32-bit subtractor: computes D = A - B, plus borrow, signed-overflow and zero flags.
- Mirrors the existing adder datapath, split into two 16-bit halves with a borrow chain between pipeline stages.
- Sits between an operand producer and a result consumer.
- Uses valid/ready handshakes on both sides, so either side may stall.

Parameters:
WIDTH, 32, operand/result width; must be even and >= 4; HALF = WIDTH/2 is derived internally.

Ports:
clk  input  1  single clock, rising-edge.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  operands A/B presented.
in_ready  output  1  block can accept operands this cycle.
A  input  WIDTH  minuend.
B  input  WIDTH  subtrahend.
out_valid  output  1  result registers hold a valid result.
out_ready  input  1  consumer accepts the result this cycle.
D  output  WIDTH  difference, A - B mod 2^WIDTH.
BOUT  output  1  borrow out: 1 when A < B, unsigned.
OVF  output  1  signed overflow of A - B.
ZERO  output  1  1 when D == 0.

Behaviour:
- Reset:
  - rst high clears v1, v2 and all data/flag registers to 0 asynchronously.
  - While rst is high: out_valid=0, D=0, BOUT=0, OVF=0, ZERO=0.
  - in_ready is combinational; per the rules below it reads 1 during reset.
  - Reset mid-operation discards every in-flight item; no partial result is ever presented.
- Stage 1, on input accept (in_valid && in_ready):
  - Computes lo = A[HALF-1:0] + ~B[HALF-1:0] + 1.
  - Registers lo[HALF-1:0] and carry c_mid = lo[HALF].
  - Registers A[WIDTH-1:HALF], B[WIDTH-1:HALF] and sets v1=1.
- Stage 2, on stage-1 advance:
  - Computes hi = Ahi + ~Bhi + c_mid.
  - Registers D = {hi[HALF-1:0], lo}.
  - BOUT = ~hi[HALF].
  - OVF = (Ahi[msb] != Bhi[msb]) && (hi[msb] != Ahi[msb]).
  - ZERO = (D == 0).
  - Sets v2=1.
- Handshake:
  - out_valid = v2.
  - adv2 = v1 && (!v2 || out_ready).
  - in_ready = !v1 || adv2. Combinational from out_ready; no combinational path from in_valid to in_ready.
  - v1 clears when adv2 occurs and no new input is accepted.
  - v2 clears on out_ready && out_valid when no adv2 occurs the same cycle.
- Latency and throughput:
  - 2 cycles from the accept edge to out_valid, with no stalls.
  - Full throughput of 1 result per cycle while out_ready is held 1.
- Stall:
  - While out_valid && !out_ready, D/BOUT/OVF/ZERO stay bit-stable.
  - The pipeline fills to 2 items, then in_ready drops to 0.
  - No item is dropped or duplicated.
- Simultaneous events:
  - Accept into stage 1, advance to stage 2 and output consume can all happen in the same cycle. All register updates use pre-edge values.
  - A full pipeline with out_ready=1 accepts a new input in that same cycle.
- Data registers load only on their enable; they are not cleared when an item leaves.
- Inputs A/B are sampled only on the accept edge; changes at other times have no effect.
- Ordering is strictly FIFO.

Test Plan:
- Reset check: assert rst mid-stream with 2 items in flight -> out_valid=0 and D=0 immediately (asynchronous); after release, in_ready=1 and no stale result appears.
- Basic subtraction: A=0x0000_0005, B=0x0000_0003, out_ready=1 -> two cycles later D=0x0000_0002, BOUT=0, OVF=0, ZERO=0.
- Borrow across halves and zero:
  - A=0x0001_0000, B=0x0000_0001 -> D=0x0000_FFFF, BOUT=0.
  - A=0x0000_0000, B=0x0000_0001 -> D=0xFFFF_FFFF, BOUT=1.
  - A=B=0x1234_5678 -> D=0, ZERO=1.
- Signed overflow:
  - A=0x8000_0000, B=0x0000_0001 -> D=0x7FFF_FFFF, OVF=1, BOUT=0.
  - A=0x7FFF_FFFF, B=0xFFFF_FFFF -> D=0x8000_0000, OVF=1, BOUT=1.
- Backpressure: stream 4 items with out_ready=0 -> in_ready falls after 2 accepts and the output stays stable; release out_ready -> all 4 results emerge in order with no loss or duplication.
- Throughput: 100 random back-to-back operand pairs, out_ready=1 -> one result per cycle after 2-cycle fill; every result matches a 33-bit reference model (D, BOUT, OVF, ZERO).
